// File: rtl/seg7_capture.sv
// Receiving end of the multiplexed 7-segment display lines: synchronises, waits for a
// stable pattern, decodes the cathodes back to a 4-bit code and stores it per position.

module seg7_capture_slot (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] code,
    output logic [3:0] code_q,
    output logic       valid
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q <= 4'hF;
            valid  <= 1'b0;
        end else if (load) begin
            code_q <= code;
            valid  <= 1'b1;
        end
    end
endmodule

module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  anodes_in,
    input  logic [6:0]  cathodes_in,
    input  logic        err_clear,
    output logic [15:0] digits_out,
    output logic [3:0]  digit_valid,
    output logic        decode_err,
    output logic        frame_done
);
    localparam int NUM_POS = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    typedef struct packed {
        logic [3:0] anodes;
        logic [6:0] cathodes;
    } sample_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] code;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] c);
        dec_t d;
        d.legal = 1'b1;
        d.code  = 4'h0;
        case (c)
            7'b1000000: d.code = 4'h0;
            7'b1111001: d.code = 4'h1;
            7'b0100100: d.code = 4'h2;
            7'b0110000: d.code = 4'h3;
            7'b0011001: d.code = 4'h4;
            7'b0010010: d.code = 4'h5;
            7'b0000010: d.code = 4'h6;
            7'b1111000: d.code = 4'h7;
            7'b0000000: d.code = 4'h8;
            7'b0010000: d.code = 4'h9;
            7'b0100001: d.code = 4'hD;
            7'b0000110: d.code = 4'hE;
            7'b1111111: d.code = 4'hF;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    sample_t                    sync1, sync2, prev;
    logic [CNT_W-1:0]           cnt;
    logic [NUM_POS-1:0]         seen;
    logic [NUM_POS-1:0][3:0]    digits;
    logic [NUM_POS-1:0]         sel, load;
    logic                       stable, accept, single, set_err;
    dec_t                       dec;

    // Two flops for metastability, a third to compare consecutive synced samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            cnt   <= '0;
        end else begin
            sync1 <= {anodes_in, cathodes_in};
            sync2 <= sync1;
            prev  <= sync2;
            if (!stable)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign stable = (sync2 == prev);
    // cnt saturates past CNT_ACC, so each stable run yields a single accept
    assign accept = stable && (cnt == CNT_ACC);
    assign sel    = ~sync2.anodes;
    assign single = (sel != '0) && ((sel & (sel - 4'd1)) == '0);
    assign dec    = decode(sync2.cathodes);

    assign load    = (accept && single && dec.legal) ? sel : '0;
    assign set_err = accept && (sel != '0) && (!single || !dec.legal);

    for (genvar k = 0; k < NUM_POS; k++) begin : g_pos
        seg7_capture_slot u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[k]),
            .code    (dec.code),
            .code_q  (digits[k]),
            .valid   (digit_valid[k])
        );
    end

    assign digits_out = digits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen       <= '0;
            frame_done <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load != '0) begin
                if (&(seen | load)) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen | load;
                end
            end
            // A new error outranks a simultaneous clear
            if (set_err)
                decode_err <= 1'b1;
            else if (err_clear)
                decode_err <= 1'b0;
        end
    end
endmodule
